// File: rtl/clock_mode_ctrl.sv
// Mode controller for the digital clock: button edge detection, CLOCK/ALARM/STOPWATCH
// mode FSM, pulse routing to the active unit, edit blink mask and alarm ring control.
module clock_mode_ctrl #(
  parameter int LONG_CYC = 100_000_000,
  parameter int RING_SEC = 30
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic        tick_2hz,
  input  logic        btn_mode,
  input  logic        btn_a,
  input  logic        btn_b,
  input  logic        btn_c,
  input  logic [1:0]  edit_field,
  input  logic [23:0] cur_hms,
  input  logic [15:0] alm_hm,
  output logic [1:0]  mode,
  output logic        tc_adjust,
  output logic        tc_up,
  output logic        tc_up_ten,
  output logic        al_adjust,
  output logic        al_up,
  output logic        al_up_ten,
  output logic        sw_run,
  output logic        sw_clear,
  output logic [5:0]  blank,
  output logic        alarm_en,
  output logic        ringing
);

  localparam int CNT_W = $clog2(LONG_CYC + 1);
  localparam int RNG_W = $clog2(RING_SEC + 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYC);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [RNG_W-1:0] RING_LOAD = RNG_W'(RING_SEC);

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'd0,
    MODE_ALARM = 2'd1,
    MODE_SW    = 2'd2
  } mode_t;

  mode_t state_q, state_d;

  // Button bit order: 0 = a, 1 = b, 2 = c, 3 = mode.
  logic [3:0] lvl, prev_q, arm_q, press;
  logic       silence;
  logic       sel_a, sel_b, sel_c;
  logic       mode_fall, hold, long_hit, mode_adv, match;
  logic       consumed_q, phase_q;
  logic [CNT_W-1:0] press_cnt;
  logic [RNG_W-1:0] ring_cnt;

  assign lvl = {btn_mode, btn_c, btn_b, btn_a};

  // A button held through reset stays unarmed until it has been seen released.
  assign press   = lvl & ~prev_q & arm_q;
  assign silence = ringing & (|press);

  assign sel_a = press[0] & ~silence;
  assign sel_b = press[1] & ~silence & ~press[0];
  assign sel_c = press[2] & ~silence & ~press[0] & ~press[1];

  // A mode press that silences the alarm is consumed for the rest of its hold.
  assign hold      = btn_mode & arm_q[3] & ~consumed_q & ~(press[3] & ringing);
  assign long_hit  = hold & (press_cnt == LONG_LAST);
  assign mode_fall = ~btn_mode & prev_q[3];
  assign mode_adv  = mode_fall && (press_cnt != '0) && (press_cnt < LONG_MAX)
                     && (edit_field == 2'd0);

  assign match = alarm_en & tick_1hz & (cur_hms == {alm_hm, 8'h00});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q     <= '0;
      arm_q      <= '0;
      consumed_q <= 1'b0;
      press_cnt  <= '0;
      alarm_en   <= 1'b0;
    end else begin
      prev_q <= lvl;
      arm_q  <= arm_q | ~lvl;
      if (!btn_mode)
        consumed_q <= 1'b0;
      else if (press[3] && ringing)
        consumed_q <= 1'b1;
      if (!btn_mode)
        press_cnt <= '0;
      else if (hold && press_cnt < LONG_MAX)
        press_cnt <= press_cnt + 1'b1;
      if (long_hit)
        alarm_en <= ~alarm_en;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ringing  <= 1'b0;
      ring_cnt <= '0;
    end else if (silence || (long_hit && alarm_en)) begin
      ringing  <= 1'b0;
      ring_cnt <= '0;
    end else if (match) begin
      ringing  <= 1'b1;
      ring_cnt <= RING_LOAD;
    end else if (ringing && tick_1hz) begin
      if (ring_cnt <= RNG_W'(1)) begin
        ringing  <= 1'b0;
        ring_cnt <= '0;
      end else begin
        ring_cnt <= ring_cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MODE_CLOCK;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (mode_adv) begin
      case (state_q)
        MODE_CLOCK: state_d = MODE_ALARM;
        MODE_ALARM: state_d = MODE_SW;
        default:    state_d = MODE_CLOCK;
      endcase
    end
  end

  assign mode = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tc_adjust <= 1'b0;
      tc_up     <= 1'b0;
      tc_up_ten <= 1'b0;
      al_adjust <= 1'b0;
      al_up     <= 1'b0;
      al_up_ten <= 1'b0;
      sw_run    <= 1'b0;
      sw_clear  <= 1'b0;
      phase_q   <= 1'b0;
    end else begin
      tc_adjust <= (state_q == MODE_CLOCK) & sel_a;
      tc_up     <= (state_q == MODE_CLOCK) & sel_b;
      tc_up_ten <= (state_q == MODE_CLOCK) & sel_c;
      al_adjust <= (state_q == MODE_ALARM) & sel_a;
      al_up     <= (state_q == MODE_ALARM) & sel_b;
      al_up_ten <= (state_q == MODE_ALARM) & sel_c;
      sw_run    <= (state_q == MODE_SW) & sel_b;
      sw_clear  <= (state_q == MODE_SW) & sel_c;
      if (tick_2hz)
        phase_q <= ~phase_q;
    end
  end

  always_comb begin
    blank = 6'b000000;
    if (phase_q && state_q != MODE_SW) begin
      case (edit_field)
        2'd1:    blank = 6'b000011;
        2'd2:    blank = 6'b001100;
        2'd3:    blank = 6'b110000;
        default: blank = 6'b000000;
      endcase
    end
  end

endmodule

// File: tb/tb_clock_mode_ctrl.sv
// Directed bench for clock_mode_ctrl with a short long-press and ring time.
module tb_clock_mode_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        tick_1hz = 1'b0, tick_2hz = 1'b0;
  logic        btn_mode = 1'b0, btn_a = 1'b0, btn_b = 1'b0, btn_c = 1'b0;
  logic [1:0]  edit_field = 2'd0;
  logic [23:0] cur_hms = 24'h000000;
  logic [15:0] alm_hm = 16'h0730;
  logic [1:0]  mode;
  logic        tc_adjust, tc_up, tc_up_ten, al_adjust, al_up, al_up_ten, sw_run, sw_clear;
  logic [5:0]  blank;
  logic        alarm_en, ringing;

  int tests = 0;
  int fails = 0;

  logic [7:0] p1, p2;

  clock_mode_ctrl #(.LONG_CYC(16), .RING_SEC(3)) dut (
    .clk(clk), .rst(rst), .tick_1hz(tick_1hz), .tick_2hz(tick_2hz),
    .btn_mode(btn_mode), .btn_a(btn_a), .btn_b(btn_b), .btn_c(btn_c),
    .edit_field(edit_field), .cur_hms(cur_hms), .alm_hm(alm_hm),
    .mode(mode), .tc_adjust(tc_adjust), .tc_up(tc_up), .tc_up_ten(tc_up_ten),
    .al_adjust(al_adjust), .al_up(al_up), .al_up_ten(al_up_ten),
    .sw_run(sw_run), .sw_clear(sw_clear), .blank(blank),
    .alarm_en(alarm_en), .ringing(ringing)
  );

  // clock / reset
  always #5 clk = ~clk;

  // {tc_adjust, tc_up, tc_up_ten, al_adjust, al_up, al_up_ten, sw_run, sw_clear}
  function automatic logic [7:0] pulses();
    return {tc_adjust, tc_up, tc_up_ten, al_adjust, al_up, al_up_ten, sw_run, sw_clear};
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // inputs change 1 time unit after the rising edge; outputs are read at the same point
  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_btns(input logic [3:0] m);
    {btn_mode, btn_c, btn_b, btn_a} = m;
  endtask

  // press a/b/c mask, capture pulses one and two cycles after the edge, release
  task automatic tap(input logic [2:0] m, output logic [7:0] first, output logic [7:0] second);
    set_btns({1'b0, m});
    step(1);
    first = pulses();
    step(1);
    second = pulses();
    set_btns(4'b0000);
    step(2);
  endtask

  task automatic short_mode(input int hold_cyc);
    btn_mode = 1'b1;
    step(hold_cyc);
    btn_mode = 1'b0;
    step(2);
  endtask

  task automatic one_sec();
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    step(1);
  endtask

  task automatic trigger_alarm();
    cur_hms  = 24'h073000;
    tick_1hz = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    cur_hms  = 24'h073001;
  endtask

  task automatic half_sec();
    tick_2hz = 1'b1;
    step(1);
    tick_2hz = 1'b0;
  endtask

  initial begin
    // reset with every button held
    set_btns(4'b1111);
    step(3);
    check_val("rst_mode", mode, 2'd0);
    check_val("rst_pulses", pulses(), 8'h00);
    check_val("rst_blank", blank, 6'h00);
    check_val("rst_alarm_en", alarm_en, 1'b0);
    check_val("rst_ringing", ringing, 1'b0);
    rst = 1'b0;
    step(1);
    check_val("held_after_rst_pulses", pulses(), 8'h00);
    step(19);
    check_val("held_after_rst_no_long", alarm_en, 1'b0);
    set_btns(4'b0000);
    step(2);
    check_val("held_after_rst_no_short", mode, 2'd0);

    tap(3'b010, p1, p2);
    check_val("b_tc_up_first", p1, 8'h40);
    check_val("b_tc_up_width", p2, 8'h00);

    // short presses advance mode
    short_mode(3);
    check_val("short1_mode", mode, 2'd1);
    short_mode(3);
    check_val("short2_mode", mode, 2'd2);
    short_mode(3);
    check_val("short3_mode", mode, 2'd0);
    edit_field = 2'd2;
    short_mode(3);
    check_val("short_edit_mode", mode, 2'd0);
    short_mode(3);
    check_val("short_edit2_mode", mode, 2'd0);
    edit_field = 2'd0;

    // long press toggles alarm_en once
    btn_mode = 1'b1;
    step(15);
    check_val("long_before", alarm_en, 1'b0);
    step(51);
    check_val("long_toggled", alarm_en, 1'b1);
    btn_mode = 1'b0;
    step(2);
    check_val("long_mode_kept", mode, 2'd0);
    check_val("long_once", alarm_en, 1'b1);

    // alarm mode routing
    short_mode(3);
    check_val("to_alarm_mode", mode, 2'd1);
    tap(3'b100, p1, p2);
    check_val("al_up_ten", p1, 8'h04);
    check_val("al_up_ten_width", p2, 8'h00);

    // stopwatch routing
    short_mode(3);
    check_val("to_sw_mode", mode, 2'd2);
    tap(3'b001, p1, p2);
    check_val("sw_a_dropped", p1 | p2, 8'h00);
    tap(3'b010, p1, p2);
    check_val("sw_run", p1, 8'h02);
    tap(3'b100, p1, p2);
    check_val("sw_clear", p1, 8'h01);
    edit_field = 2'd3;
    half_sec();
    check_val("sw_blank_zero", blank, 6'h00);
    half_sec();
    edit_field = 2'd0;
    short_mode(3);
    check_val("back_to_clock", mode, 2'd0);

    // alarm match, ring countdown
    trigger_alarm();
    check_val("ring_start", ringing, 1'b1);
    one_sec();
    one_sec();
    check_val("ring_after_2", ringing, 1'b1);
    one_sec();
    check_val("ring_after_3", ringing, 1'b0);

    // silence by btn_b consumes the press
    trigger_alarm();
    check_val("ring_retrig", ringing, 1'b1);
    tap(3'b010, p1, p2);
    check_val("silence_no_pulse", p1 | p2, 8'h00);
    check_val("silence_ringing", ringing, 1'b0);
    tap(3'b010, p1, p2);
    check_val("after_silence_tc_up", p1, 8'h40);

    // silence by btn_mode consumes the whole hold
    trigger_alarm();
    btn_mode = 1'b1;
    step(1);
    check_val("mode_silence_ringing", ringing, 1'b0);
    step(20);
    btn_mode = 1'b0;
    step(2);
    check_val("mode_silence_mode", mode, 2'd0);
    check_val("mode_silence_alarm_en", alarm_en, 1'b1);

    // match and silence press in the same cycle
    trigger_alarm();
    cur_hms  = 24'h073000;
    tick_1hz = 1'b1;
    btn_a    = 1'b1;
    step(1);
    tick_1hz = 1'b0;
    cur_hms  = 24'h073001;
    check_val("match_vs_silence", ringing, 1'b0);
    check_val("match_vs_silence_pulse", pulses(), 8'h00);
    btn_a = 1'b0;
    step(2);

    // blink mask
    edit_field = 2'd3;
    step(1);
    check_val("blank_phase0", blank, 6'b000000);
    half_sec();
    check_val("blank_hour", blank, 6'b110000);
    half_sec();
    check_val("blank_off", blank, 6'b000000);
    half_sec();
    check_val("blank_hour2", blank, 6'b110000);
    edit_field = 2'd1;
    #1;
    check_val("blank_sec", blank, 6'b000011);
    edit_field = 2'd2;
    #1;
    check_val("blank_min", blank, 6'b001100);
    edit_field = 2'd0;
    #1;
    check_val("blank_none", blank, 6'b000000);

    // a + c together: priority a
    tap(3'b101, p1, p2);
    check_val("prio_a_over_c", p1, 8'h80);
    check_val("prio_width", p2, 8'h00);
    tap(3'b110, p1, p2);
    check_val("prio_b_over_c", p1, 8'h40);

    // mode release together with a b press
    btn_mode = 1'b1;
    step(3);
    btn_mode = 1'b0;
    btn_b    = 1'b1;
    step(1);
    check_val("release_and_b_pulse", pulses(), 8'h40);
    check_val("release_and_b_mode", mode, 2'd1);
    btn_b = 1'b0;
    step(2);

    // reset mid-hold
    btn_b = 1'b1;
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    step(2);
    check_val("rst_mid_mode", mode, 2'd0);
    check_val("rst_mid_alarm_en", alarm_en, 1'b0);
    check_val("rst_mid_pulses", pulses(), 8'h00);
    btn_b = 1'b0;
    step(2);
    tap(3'b010, p1, p2);
    check_val("rst_mid_repress", p1, 8'h40);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
